// File: rtl/visualizador_marcador_pkg.sv
// -----------------------------------------------------------------------------
// pkg_visualizador
// Shared types and constants for the scoreboard display stage.
//   seg7_t      : seven-segment pattern {g,f,e,d,c,b,a}, active-low
//   SEG_BLANK   : all segments off
//   SEG_DASH    : only segment g lit ('-')
//   SEG_E       : letter 'E'
//   DIG_*       : slot index of each content within the 8-digit frame
//   hex_a_seg7  : 4-bit value -> active-low seven-segment pattern
// -----------------------------------------------------------------------------
package pkg_visualizador;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;
    localparam seg7_t SEG_DASH  = 7'b0111111;
    localparam seg7_t SEG_E     = 7'b0000110;

    localparam logic [2:0] DIG_DADO0   = 3'd0;
    localparam logic [2:0] DIG_DADO1   = 3'd1;
    localparam logic [2:0] DIG_CONTEO0 = 3'd2;
    localparam logic [2:0] DIG_CONTEO1 = 3'd3;
    localparam logic [2:0] DIG_GANADOR = 3'd4;

    function automatic seg7_t hex_a_seg7(input logic [3:0] valor);
        seg7_t s;
        case (valor)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/visualizador_marcador_decodificador_7seg.sv
// -----------------------------------------------------------------------------
// decodificador_7seg
// Combinational seven-segment decoder for the currently selected digit.
//   valor     in  4  hex value to show
//   blanco    in  1  force all segments off (highest priority)
//   guion     in  1  force '-' (over the hex value)
//   segmentos out 7  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module decodificador_7seg
    import pkg_visualizador::*;
(
    input  logic [3:0] valor,
    input  logic       blanco,
    input  logic       guion,
    output seg7_t      segmentos
);

    always_comb begin
        segmentos = hex_a_seg7(valor);
        if (blanco) begin
            segmentos = SEG_BLANK;
        end else if (guion) begin
            segmentos = SEG_DASH;
        end
    end

endmodule

// File: rtl/visualizador_marcador.sv
// -----------------------------------------------------------------------------
// visualizador_marcador
// Time-multiplexes dice faces, win counts and last winner onto an 8-digit
// common-anode seven-segment display. Inputs are snapshotted once per frame
// so no digit tears mid-frame; a new winner blinks digit 4 for BLINK_FRAMES.
//   clk_i       in  1  system clock
//   rst_i       in  1  synchronous reset, active-high
//   dados_i     in  6  {die J1[5:3], die J0[2:0]}
//   conteos_i   in  8  {wins J1[7:4], wins J0[3:0]}
//   ganador_i   in  2  01 J0, 10 J1, 11 tie, 00 none
//   habilita_i  in  1  display enable (scanning never stops)
//   anodos_o    out 8  anode select, active-low
//   segmentos_o out 7  {g,f,e,d,c,b,a}, active-low
//   punto_o     out 1  decimal point, active-low
// -----------------------------------------------------------------------------
module visualizador_marcador
    import pkg_visualizador::*;
#(
    parameter int REFRESH_CYCLES = 100_000,
    parameter int NUM_DIGITS     = 8,
    parameter int BLINK_FRAMES   = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] dados_i,
    input  logic [7:0] conteos_i,
    input  logic [1:0] ganador_i,
    input  logic       habilita_i,
    output logic [7:0] anodos_o,
    output logic [6:0] segmentos_o,
    output logic       punto_o
);

    localparam int PW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    localparam logic [PW-1:0] PRESC_MAX   = PW'(REFRESH_CYCLES - 1);
    localparam logic [2:0]    IDX_MAX     = 3'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_CARGA = BW'(BLINK_FRAMES);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          primero;
    logic [5:0]    snap_dados;
    logic [7:0]    snap_conteos;
    logic [1:0]    snap_ganador;
    logic [BW-1:0] parpadeo;

    logic          tick;
    logic          wrap;
    logic          captura;
    logic          cambio;

    logic [5:0]    vista_dados;
    logic [7:0]    vista_conteos;
    logic [1:0]    vista_ganador;

    logic [3:0]    sel_valor;
    logic          sel_blanco;
    logic          sel_guion;
    logic          sel_punto_n;
    seg7_t         seg_dec;

    assign tick    = (presc == PRESC_MAX);
    assign wrap    = tick && (idx == IDX_MAX);
    assign captura = primero || wrap;
    assign cambio  = (ganador_i != snap_ganador) && (ganador_i != 2'b00);

    // On the very first cycle after reset the snapshot registers are being
    // loaded in the same edge as the first digit is registered, so the digit
    // path reads the live inputs instead; this is exactly the value captured.
    assign vista_dados   = primero ? dados_i   : snap_dados;
    assign vista_conteos = primero ? conteos_i : snap_conteos;
    assign vista_ganador = primero ? ganador_i : snap_ganador;

    always_comb begin
        sel_valor   = 4'h0;
        sel_blanco  = 1'b0;
        sel_guion   = 1'b0;
        sel_punto_n = 1'b1;
        case (idx)
            DIG_DADO0: begin
                sel_valor = {1'b0, vista_dados[2:0]};
                sel_guion = (vista_dados[2:0] == 3'd0) || (vista_dados[2:0] == 3'd7);
            end
            DIG_DADO1: begin
                sel_valor = {1'b0, vista_dados[5:3]};
                sel_guion = (vista_dados[5:3] == 3'd0) || (vista_dados[5:3] == 3'd7);
            end
            DIG_CONTEO0: begin
                sel_valor   = vista_conteos[3:0];
                sel_punto_n = 1'b0;
            end
            DIG_CONTEO1: begin
                sel_valor = vista_conteos[7:4];
            end
            DIG_GANADOR: begin
                case (vista_ganador)
                    2'b01:   sel_valor = 4'h0;
                    2'b10:   sel_valor = 4'h1;
                    2'b11:   sel_valor = 4'hE;
                    default: sel_guion = 1'b1;
                endcase
                // Odd counter values are the "off" half of the blink cycle.
                sel_blanco = (parpadeo != '0) && parpadeo[0];
            end
            default: begin
                sel_blanco = 1'b1;
            end
        endcase
    end

    decodificador_7seg u_deco (
        .valor     (sel_valor),
        .blanco    (sel_blanco),
        .guion     (sel_guion),
        .segmentos (seg_dec)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc        <= '0;
            idx          <= '0;
            primero      <= 1'b1;
            snap_dados   <= '0;
            snap_conteos <= '0;
            snap_ganador <= '0;
            parpadeo     <= '0;
            anodos_o     <= 8'hFF;
            segmentos_o  <= SEG_BLANK;
            punto_o      <= 1'b1;
        end else begin
            primero <= 1'b0;

            if (tick) begin
                presc <= '0;
                idx   <= (idx == IDX_MAX) ? 3'd0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            if (captura) begin
                snap_dados   <= dados_i;
                snap_conteos <= conteos_i;
                snap_ganador <= ganador_i;
            end

            // A fresh winner always restarts the blink, even mid-blink.
            if (captura && cambio) begin
                parpadeo <= BLINK_CARGA;
            end else if (wrap && (parpadeo != '0)) begin
                parpadeo <= parpadeo - 1'b1;
            end

            anodos_o    <= habilita_i ? ~(8'b1 << idx) : 8'hFF;
            segmentos_o <= seg_dec;
            punto_o     <= sel_punto_n;
        end
    end

endmodule

// File: tb/tb_visualizador_marcador.sv
module tb_visualizador_marcador;

    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [6:0] S_DA = 7'b0111111;
    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_1  = 7'b1111001;
    localparam logic [6:0] S_3  = 7'b0110000;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_6  = 7'b0000010;
    localparam logic [6:0] S_A  = 7'b0001000;
    localparam logic [6:0] S_E  = 7'b0000110;
    localparam logic [6:0] S_F  = 7'b0001110;

    logic       clk_pi = 1'b0;
    logic       rst_i;
    logic [5:0] dados_i;
    logic [7:0] conteos_i;
    logic [1:0] ganador_i;
    logic       habilita_i;
    logic [7:0] anodos_o;
    logic [6:0] segmentos_o;
    logic       punto_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_pi = ~clk_pi;

    visualizador_marcador #(
        .REFRESH_CYCLES (4),
        .NUM_DIGITS     (8),
        .BLINK_FRAMES   (4)
    ) dut (
        .clk_i       (clk_pi),
        .rst_i       (rst_i),
        .dados_i     (dados_i),
        .conteos_i   (conteos_i),
        .ganador_i   (ganador_i),
        .habilita_i  (habilita_i),
        .anodos_o    (anodos_o),
        .segmentos_o (segmentos_o),
        .punto_o     (punto_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at the falling edge of the first cycle of digit k; checks all
    // four cycles of that digit and returns on the first cycle of the next.
    task automatic check_digito(input int k, input logic [6:0] seg, input logic pt);
        logic [7:0] an;
        an = ~(8'b1 << k);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("anodo d%0d c%0d", k, c), anodos_o, an);
            chk($sformatf("seg d%0d c%0d", k, c), {1'b0, segmentos_o}, {1'b0, seg});
            chk($sformatf("punto d%0d c%0d", k, c), {7'b0, punto_o}, {7'b0, pt});
            @(negedge clk_pi);
        end
    endtask

    task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [6:0] s4);
        check_digito(0, s0, 1'b1);
        check_digito(1, s1, 1'b1);
        check_digito(2, s2, 1'b0);
        check_digito(3, s3, 1'b1);
        check_digito(4, s4, 1'b1);
        check_digito(5, S_BL, 1'b1);
        check_digito(6, S_BL, 1'b1);
        check_digito(7, S_BL, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " anodos"}, anodos_o, 8'hFF);
        chk({tag, " seg"}, {1'b0, segmentos_o}, 8'h7F);
        chk({tag, " punto"}, {7'b0, punto_o}, 8'h01);
    endtask

    initial begin
        rst_i      = 1'b1;
        dados_i    = 6'b110_011;
        conteos_i  = 8'h5A;
        ganador_i  = 2'b01;
        habilita_i = 1'b1;

        repeat (3) @(posedge clk_pi);
        @(negedge clk_pi);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        @(negedge clk_pi);

        // F1: first snapshot, blink counter loaded to 4 (even -> visible)
        check_frame(S_3, S_6, S_A, S_5, S_0);

        // F2: counts change mid-frame, must not show until next frame
        check_digito(0, S_3, 1'b1);
        check_digito(1, S_6, 1'b1);
        conteos_i = 8'hFF;
        check_digito(2, S_A, 1'b0);
        check_digito(3, S_5, 1'b1);
        check_digito(4, S_BL, 1'b1);
        check_digito(5, S_BL, 1'b1);
        check_digito(6, S_BL, 1'b1);
        check_digito(7, S_BL, 1'b1);

        // F3: new counts visible; invalid dice / no winner queued for F4
        check_digito(0, S_3, 1'b1);
        check_digito(1, S_6, 1'b1);
        check_digito(2, S_F, 1'b0);
        check_digito(3, S_F, 1'b1);
        check_digito(4, S_0, 1'b1);
        dados_i   = 6'b111_000;
        ganador_i = 2'b00;
        check_digito(5, S_BL, 1'b1);
        check_digito(6, S_BL, 1'b1);
        check_digito(7, S_BL, 1'b1);

        // F4: counter 1 -> blank; F5: counter 0 -> '-' for no winner
        check_frame(S_DA, S_DA, S_F, S_F, S_BL);
        check_digito(0, S_DA, 1'b1);
        check_digito(1, S_DA, 1'b1);
        check_digito(2, S_F, 1'b0);
        check_digito(3, S_F, 1'b1);
        check_digito(4, S_DA, 1'b1);
        ganador_i = 2'b11;
        check_digito(5, S_BL, 1'b1);
        check_digito(6, S_BL, 1'b1);
        check_digito(7, S_BL, 1'b1);

        // F6: tie loads blink (4) -> 'E'; F7: 3 -> blank, J1 wins meanwhile
        check_frame(S_DA, S_DA, S_F, S_F, S_E);
        check_digito(0, S_DA, 1'b1);
        check_digito(1, S_DA, 1'b1);
        check_digito(2, S_F, 1'b0);
        check_digito(3, S_F, 1'b1);
        check_digito(4, S_BL, 1'b1);
        ganador_i = 2'b10;
        check_digito(5, S_BL, 1'b1);
        check_digito(6, S_BL, 1'b1);
        check_digito(7, S_BL, 1'b1);

        // F8..F13: blink restarted: 4,3,2,1 then steady '1'
        check_frame(S_DA, S_DA, S_F, S_F, S_1);
        check_frame(S_DA, S_DA, S_F, S_F, S_BL);
        check_frame(S_DA, S_DA, S_F, S_F, S_1);
        check_frame(S_DA, S_DA, S_F, S_F, S_BL);
        check_frame(S_DA, S_DA, S_F, S_F, S_1);
        check_frame(S_DA, S_DA, S_F, S_F, S_1);

        // F14: display disabled for 10 cycles starting at digit 2
        check_digito(0, S_DA, 1'b1);
        check_digito(1, S_DA, 1'b1);
        chk("hab pre anodo", anodos_o, 8'hFB);
        habilita_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_pi);
            chk($sformatf("hab off c%0d", i), anodos_o, 8'hFF);
        end
        habilita_i = 1'b1;
        @(negedge clk_pi);
        chk("hab on anodo", anodos_o, 8'hEF);
        chk("hab on seg", {1'b0, segmentos_o}, {1'b0, S_1});
        @(negedge clk_pi);
        check_digito(5, S_BL, 1'b1);
        check_digito(6, S_BL, 1'b1);
        check_digito(7, S_BL, 1'b1);

        // F15: scanning phase unaffected by the disable
        check_frame(S_DA, S_DA, S_F, S_F, S_1);

        // F16: reset mid-frame aborts; new frame re-snapshots and reloads blink
        check_digito(0, S_DA, 1'b1);
        check_digito(1, S_DA, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_pi);
        check_reset_outputs("midreset1");
        @(negedge clk_pi);
        check_reset_outputs("midreset2");
        rst_i = 1'b0;
        @(negedge clk_pi);
        check_frame(S_DA, S_DA, S_F, S_F, S_1);
        check_frame(S_DA, S_DA, S_F, S_F, S_BL);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/visualizador_marcador.md
Name: visualizador_marcador

Overview:
Display stage directly downstream of the dice-game top level. It consumes the per-player die faces, per-player win counts and the last-winner flags, and time-multiplexes them onto the 8-digit common-anode seven-segment display. Inputs are snapshotted once per frame so no digit ever tears. A winner change makes the winner digit blink for a fixed number of frames.

Parameters:
REFRESH_CYCLES, 100_000, clock cycles each digit stays lit (>=2)
NUM_DIGITS, 8, digits scanned per frame (fixed at 8, must match anode width)
BLINK_FRAMES, 64, frames of blinking after a new winner (>=2, even)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
dados_i  in  6  {die J1[5:3], die J0[2:0]}; valid faces 1..6
conteos_i  in  8  {wins J1[7:4], wins J0[3:0]}
ganador_i  in  2  last winner flags: 01 J0, 10 J1, 11 tie, 00 none
habilita_i  in  1  1 = display on; 0 = all anodes off, scanning continues
anodos_o  out  8  anode select, active-low, one-hot-zero
segmentos_o  out  7  {g,f,e,d,c,b,a}, active-low
punto_o  out  1  decimal point, active-low

Behaviour:
- Reset (rst_i sampled high on clk_i): prescaler=0, digit index=0, snapshot regs=0, blink counter=0, anodos_o=8'hFF, segmentos_o=7'h7F, punto_o=1. Reset asserted mid-frame aborts the frame immediately; the first frame after release re-snapshots.
- Prescaler counts 0..REFRESH_CYCLES-1. At terminal count: tick=1, prescaler wraps to 0, digit index increments modulo NUM_DIGITS.
- Snapshot: dados_i, conteos_i and ganador_i are captured on the first cycle after reset release. They are captured again on every tick where the index wraps 7->0. Between snapshots, input changes are ignored.
- Digit map (index -> content):
  - 0: die J0.
  - 1: die J1.
  - 2: wins J0 as hex, with punto_o=0 (separator).
  - 3: wins J1 as hex.
  - 4: winner: '0' for 01, '1' for 10, 'E' for 11, '-' for 00.
  - 5-7: blank (7'h7F).
- Die faces 0 or 7 display '-' (7'b0111111).
- Encodings (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Latency: anodos_o, segmentos_o and punto_o are registered and update exactly 1 cycle after the index changes. anodos_o bit k is 0 only while the displayed index equals k and habilita_i=1.
- Blink:
  - At a snapshot, if the new ganador differs from the previous snapshot and is nonzero, load the blink counter with BLINK_FRAMES.
  - The counter decrements at each frame wrap while nonzero.
  - While it is nonzero and its bit0=1, digit 4 shows blank (anode still driven).
  - A new winner change during blinking reloads the counter to BLINK_FRAMES.
- habilita_i=0: anodos_o=8'hFF on the next cycle. Prescaler, index, snapshot and blink logic continue unaffected.
- All arithmetic is unsigned. The prescaler width is $clog2(REFRESH_CYCLES) and the blink counter width is $clog2(BLINK_FRAMES+1); neither ever overflows.

Decomposition:
- Package pkg_visualizador:
  - typedef seg7_t (logic [6:0]);
  - constants SEG_BLANK, SEG_DASH, SEG_E and the digit-slot indices (DIG_DADO0..DIG_GANADOR);
  - function hex_a_seg7.
- One combinational sub-module decodificador_7seg (4-bit value + blank/dash controls -> seg7_t), instanced once on the selected digit.
- Prescaler, scanner, snapshot and blink logic stay in the top module.

Test Plan:
- REFRESH_CYCLES=4, reset held 3 cycles, then released -> during reset anodos_o=FF, segmentos_o=7F, punto_o=1; after release anodos_o walks FE,FD,FB,...,7F, each value held exactly 4 cycles, then repeats.
- dados_i=6'b110_011, conteos_i=8'h5A, ganador_i=01 stable -> segments per digit 0..4 are 0110000, 0000010, 0001000 (with punto_o=0 on digit 2), 0010010, 1000000; digits 5-7 give 7F.
- dados_i=6'b111_000 -> digits 0 and 1 show 0111111. ganador_i=00 -> digit 4 shows 0111111. ganador_i=11 -> digit 4 shows 0000110.
- Change conteos_i to 8'hFF mid-frame (index 2) -> rest of the frame still shows 5/A; the next frame shows F/F (0001110).
- BLINK_FRAMES=4, ganador_i 01->10 -> digit 4 alternates blank / 1111001 for 4 frames, then stays 1111001. A second change during blinking restarts the 4 frames.
- habilita_i=0 for 10 cycles mid-frame -> anodos_o=FF from the next cycle. After re-enable, the index is where free-running scanning predicts, with no phase reset.
